dog_diff_stream: RTL
====================

// Module: dog_diff_stream
// PURPOSE
// - Streaming signed subtractor for the SIFT difference-of-Gaussian stage. Each beat takes LANES
//   pixel pairs from two adjacent blur layers (e.g. blur5x5 - blur3x3) and outputs signed
//   differences, a per-lane |diff| > thresh candidate flag, raster position and an end-of-frame pulse.
// - Sits between the blur filters and the keypoint extrema detector.
// PARAMETERS
// - DATA_W  9    unsigned input pixel width per lane
// - OUT_W   10   signed output width per lane (natural width is DATA_W+1)
// - LANES   1    pixels per beat; COLS % LANES == 0 is required
// - COLS    640  image width in pixels
// - ROWS    480  image height in pixels
// - COL_W   $clog2(COLS), ROW_W $clog2(ROWS): derived localparams, not overridable
// PORTS
// - clk         in   1              rising-edge clock
// - rst_n       in   1              synchronous active-low reset
// - in_valid    in   1              input beat valid; no backpressure
// - in_a        in   LANES*DATA_W   minuend pixels, lane k = [k*DATA_W +: DATA_W]
// - in_b        in   LANES*DATA_W   subtrahend pixels, same lane packing
// - thresh      in   DATA_W         unsigned contrast threshold, sampled with the input beat
// - out_valid   out  1              output beat valid
// - out_diff    out  LANES*OUT_W    signed a-b per lane, lane k = [k*OUT_W +: OUT_W]
// - out_flag    out  LANES          lane k: |a_k - b_k| > thresh (strict)
// - out_col     out  COL_W          column of lane 0 of the output beat
// - out_row     out  ROW_W          row of the output beat
// - frame_done  out  1              1-cycle pulse coincident with the last beat of a frame
// BEHAVIOUR
// - Reset, synchronous, rst_n==0 at posedge: all outputs 0, pipeline valid bits 0, counters 0.
// - Reset mid-frame discards in-flight beats. The first beat after reset is row 0, col 0.
// - Latency is fixed at 2 cycles: a beat accepted at edge N appears on the outputs after edge N+2.
//   Output fields are held until the next output beat, and only out_valid qualifies them.
// - Stage 1:
//   - d_k = {1'b0,a_k} - {1'b0,b_k}, computed at DATA_W+1 bits signed. Range ±(2^DATA_W - 1).
//   - Register d_k, thresh and the lane-0 position.
// - Stage 2:
//   - abs_k = |d_k| fits in DATA_W bits unsigned; out_flag[k] = abs_k > thresh_reg.
//   - The flag is always computed on the unsaturated, unwrapped d_k.
//   - out_diff sign-extension or narrowing follows the CONFIGURATION section.
// - Position counters:
//   - They advance only on accepted beats. col steps by LANES and wraps to 0 after COLS-LANES.
//   - row increments on each col wrap and wraps to 0 after ROWS-1.
//   - No stall between frames; the next beat starts frame+1 at (0,0).
// - frame_done = out_valid && out_col==COLS-LANES && out_row==ROWS-1.
// - Gaps: in_valid may drop on any cycle. Bubbles propagate as out_valid=0 and counters hold.
// - A beat arriving while a frame_done beat is in the pipeline is handled normally (back-to-back frames).
// - thresh may change every beat; each beat uses the thresh value present with it at input.
// CONFIGURATION
// - Macro DOG_SAT_EN:
//   - Defined, with OUT_W < DATA_W+1: out_diff saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - Not defined, with OUT_W < DATA_W+1: out_diff keeps the low OUT_W bits (two's-complement wrap).
//   - OUT_W >= DATA_W+1: sign-extend in both builds; the macro has no effect.
// TESTING
// - Basic: default params, a=5,b=6 then a=6,b=5, thresh=0.
//   -> out_diff=-1 (10'h3FF) then +1, flags 1,1, latency exactly 2 cycles.
// - Extremes: a=511,b=0 -> +511; a=0,b=511 -> -511 (10'h201), flag=1 with thresh=510;
//   a=b=200 -> 0, flag=0 with thresh=0.
// - Threshold: a=100,b=90, thresh=10 -> flag=0; thresh=9 -> flag=1; thresh changed every beat is honoured per beat.
// - Raster, LANES=4, COLS=8, ROWS=2, 4 beats + 2 gap cycles.
//   -> cols 0,4,0,4 / rows 0,0,1,1; frame_done only on beat 4; 5th beat at (0,0).
// - Saturation, OUT_W=8, a=300,b=0:
//   - With DOG_SAT_EN -> out_diff=127, flag=1.
//   - Without -> out_diff=8'h2C (300 wrapped), flag=1.
//   - a=0,b=300 -> -128 with DOG_SAT_EN.
// - Reset mid-frame: 10 beats, rst_n=0 for 1 cycle with beats in flight.
//   -> out_valid=0 for 2 cycles after reset, next beat at (0,0), no spurious frame_done.

Source files
------------

// File: rtl/dog_diff_stream.sv
// rtl/dog_diff_stream.sv - streaming signed a-b subtractor with per-lane contrast flag and raster position
// Optional macro DOG_SAT_EN: saturate out_diff instead of wrapping when OUT_W < DATA_W+1.
module dog_diff_stream #(
    parameter int DATA_W = 9,
    parameter int OUT_W  = 10,
    parameter int LANES  = 1,
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0]       thresh,
    output logic                    out_valid,
    output logic [LANES*OUT_W-1:0]  out_diff,
    output logic [LANES-1:0]        out_flag,
    output logic [COL_W-1:0]        out_col,
    output logic [ROW_W-1:0]        out_row,
    output logic                    frame_done
);
    localparam int DI_W = DATA_W + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - LANES);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;

    logic signed [DI_W-1:0] in_diff [LANES];
    logic                   s1_valid;
    logic signed [DI_W-1:0] s1_diff [LANES];
    logic [DATA_W-1:0]      s1_thresh;
    logic [COL_W-1:0]       s1_col;
    logic [ROW_W-1:0]       s1_row;
    logic [LANES*OUT_W-1:0] s1_out;
    logic [LANES-1:0]       s1_flag;

    logic                   s2_valid;
    logic                   s2_last;
    logic [LANES*OUT_W-1:0] s2_diff;
    logic [LANES-1:0]       s2_flag;
    logic [COL_W-1:0]       s2_col;
    logic [ROW_W-1:0]       s2_row;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] mag;

        assign in_diff[k] = $signed({1'b0, in_a[k*DATA_W +: DATA_W]})
                          - $signed({1'b0, in_b[k*DATA_W +: DATA_W]});
        // Magnitude of a DATA_W+1 signed difference always fits in DATA_W bits.
        assign mag        = DATA_W'(s1_diff[k][DATA_W] ? -s1_diff[k] : s1_diff[k]);
        assign s1_flag[k] = mag > s1_thresh;

        if (OUT_W >= DI_W) begin : g_ext
            assign s1_out[k*OUT_W +: OUT_W] = OUT_W'(s1_diff[k]);
        end else begin : g_narrow
`ifdef DOG_SAT_EN
            localparam logic signed [DI_W-1:0] SAT_HI = DI_W'((1 << (OUT_W - 1)) - 1);
            localparam logic signed [DI_W-1:0] SAT_LO = ~SAT_HI;
            assign s1_out[k*OUT_W +: OUT_W] = (s1_diff[k] > SAT_HI) ? SAT_HI[OUT_W-1:0] :
                                              (s1_diff[k] < SAT_LO) ? SAT_LO[OUT_W-1:0] :
                                              s1_diff[k][OUT_W-1:0];
`else
            assign s1_out[k*OUT_W +: OUT_W] = s1_diff[k][OUT_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (in_valid) begin
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + COL_W'(LANES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_thresh <= '0;
            s1_col    <= '0;
            s1_row    <= '0;
            for (int k = 0; k < LANES; k++) s1_diff[k] <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_thresh <= thresh;
                s1_col    <= col_cnt;
                s1_row    <= row_cnt;
                for (int k = 0; k < LANES; k++) s1_diff[k] <= in_diff[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_diff  <= '0;
            s2_flag  <= '0;
            s2_col   <= '0;
            s2_row   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_diff <= s1_out;
                s2_flag <= s1_flag;
                s2_col  <= s1_col;
                s2_row  <= s1_row;
                s2_last <= (s1_col == COL_LAST) && (s1_row == ROW_LAST);
            end
        end
    end

    // Output register: a beat accepted at edge N is visible after edge N+2; fields hold between beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_diff   <= '0;
            out_flag   <= '0;
            out_col    <= '0;
            out_row    <= '0;
        end else begin
            out_valid  <= s2_valid;
            frame_done <= s2_valid && s2_last;
            if (s2_valid) begin
                out_diff <= s2_diff;
                out_flag <= s2_flag;
                out_col  <= s2_col;
                out_row  <= s2_row;
            end
        end
    end
endmodule
